// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game controller and its datapath.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        MISS  = 3'd3,
        OVER  = 3'd4
    } game_state_t;

    localparam int SCORE_W          = 8;
    localparam int LIVES_W          = 2;
    localparam int BALL_Y_W         = 9;
    localparam int SERVE_CNT_W      = 8;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_LIVES        = 3;
    localparam int DEF_MISS_Y       = 448;

    function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous level, followed by a registered
// one-cycle rising-edge pulse.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Game sequencing for VGA pong: serve hold, play enable, miss handling,
// score and lives bookkeeping.
//
// state | meaning
// IDLE  | waiting for first start press, everything cleared
// SERVE | ball held at serve position for SERVE_FRAMES frame ticks
// PLAY  | ball moves; paddle hits score, a miss costs a life
// MISS  | one-cycle decision: re-serve or game over
// OVER  | game_over shown, score/lives frozen until start
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int unsigned LIVES        = DEF_LIVES,
    parameter int unsigned MISS_Y       = DEF_MISS_Y
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic                start,
    input  logic [BALL_Y_W-1:0] ball_y,
    input  logic                paddle_hit,
    output logic                ball_load,
    output logic                ball_run,
    output logic [SCORE_W-1:0]  score,
    output logic [LIVES_W-1:0]  lives,
    output logic                game_over
);

    localparam logic [SERVE_CNT_W-1:0] SERVE_LOAD = SERVE_CNT_W'(SERVE_FRAMES);
    localparam logic [LIVES_W-1:0]     LIVES_LOAD = LIVES_W'(LIVES);
    localparam logic [BALL_Y_W-1:0]    MISS_Y_C   = BALL_Y_W'(MISS_Y);

    logic start_rise;

    game_state_t            state_q;
    logic [SERVE_CNT_W-1:0] serve_cnt_q;
    logic [SCORE_W-1:0]     score_q;
    logic [LIVES_W-1:0]     lives_q;
    logic                   ball_load_q;
    logic                   ball_run_q;
    logic                   game_over_q;

    edge_sync u_start_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (start),
        .rise_o (start_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            serve_cnt_q <= '0;
            score_q     <= '0;
            lives_q     <= '0;
            ball_load_q <= 1'b0;
            ball_run_q  <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            ball_load_q <= 1'b0;
            case (state_q)
                IDLE, OVER: begin
                    if (start_rise) begin
                        score_q     <= '0;
                        lives_q     <= LIVES_LOAD;
                        serve_cnt_q <= SERVE_LOAD;
                        state_q     <= SERVE;
                        ball_load_q <= 1'b1;
                        ball_run_q  <= 1'b0;
                        game_over_q <= 1'b0;
                    end
                end
                SERVE: begin
                    if (frame_tick) begin
                        serve_cnt_q <= serve_cnt_q - SERVE_CNT_W'(1);
                        if (serve_cnt_q == SERVE_CNT_W'(1)) begin
                            state_q    <= PLAY;
                            ball_run_q <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (paddle_hit)
                        score_q <= score_sat_inc(score_q);
                    // A hit and a miss on the same cycle both count.
                    if (frame_tick && (ball_y >= MISS_Y_C)) begin
                        lives_q    <= lives_q - LIVES_W'(1);
                        state_q    <= MISS;
                        ball_run_q <= 1'b0;
                    end
                end
                MISS: begin
                    if (lives_q == '0) begin
                        state_q     <= OVER;
                        game_over_q <= 1'b1;
                    end else begin
                        serve_cnt_q <= SERVE_LOAD;
                        state_q     <= SERVE;
                        ball_load_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    ball_run_q  <= 1'b0;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end

    assign ball_load = ball_load_q;
    assign ball_run  = ball_run_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: stimulus queues expected snapshots,
// a negedge monitor pops them on every ball_load pulse or probe strobe.
module tb_pong_game_ctrl;

    localparam int K_LOAD  = 0;
    localparam int K_PROBE = 1;

    typedef struct {
        int         kind;
        string      name;
        logic       run;
        logic [7:0] score;
        logic [1:0] lives;
        logic       go;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [8:0] ball_y = '0;
    logic       paddle_hit = 1'b0;
    logic       ball_load;
    logic       ball_run;
    logic [7:0] score;
    logic [1:0] lives;
    logic       game_over;

    logic probe = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   load_cnt = 0;
    int   exp_loads = 0;
    exp_t q[$];

    pong_game_ctrl #(
        .SERVE_FRAMES (3),
        .LIVES        (3),
        .MISS_Y       (448)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .ball_y     (ball_y),
        .paddle_hit (paddle_hit),
        .ball_load  (ball_load),
        .ball_run   (ball_run),
        .score      (score),
        .lives      (lives),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
        $fatal(1, "watchdog");
    end

    task automatic check_event(input int kind);
        exp_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_%s: got run=%0b score=%0d lives=%0d go=%0b with nothing expected",
                     (kind == K_LOAD) ? "load" : "probe", ball_run, score, lives, game_over);
            return;
        end
        e = q.pop_front();
        if (e.kind != kind || ball_run !== e.run || score !== e.score || lives !== e.lives ||
            game_over !== e.go || (e.cyc >= 0 && cyc != e.cyc)) begin
            fails++;
            $display("FAIL %s: got kind=%0d run=%0b score=%0d lives=%0d go=%0b cyc=%0d, want kind=%0d run=%0b score=%0d lives=%0d go=%0b cyc=%0d",
                     e.name, kind, ball_run, score, lives, game_over, cyc,
                     e.kind, e.run, e.score, e.lives, e.go, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (ball_load) begin
            load_cnt++;
            check_event(K_LOAD);
        end
        if (probe)
            check_event(K_PROBE);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input string name, input logic run, input int sc,
                        input int lv, input logic go, input int c);
        exp_t e;
        e.kind = kind; e.name = name; e.run = run; e.score = 8'(sc);
        e.lives = 2'(lv); e.go = go; e.cyc = c;
        q.push_back(e);
        if (kind == K_LOAD)
            exp_loads++;
    endtask

    task automatic expect_now(input string name, input logic run, input int sc,
                              input int lv, input logic go);
        push(K_PROBE, name, run, sc, lv, go, -1);
        probe = 1'b1;
        step(1);
        probe = 1'b0;
    endtask

    task automatic frame(input int y);
        ball_y = 9'(y);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic hit();
        paddle_hit = 1'b1;
        step(1);
        paddle_hit = 1'b0;
        step(1);
    endtask

    task automatic press();
        start = 1'b1;
        step(6);
        start = 1'b0;
        step(2);
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        expect_now("reset_state", 1'b0, 0, 0, 1'b0);

        // held start: one load pulse, exactly three edges after the first sampling edge
        push(K_LOAD, "first_load", 1'b0, 0, 3, 1'b0, cyc + 4);
        start = 1'b1;
        step(5);
        hit();
        expect_now("hit_in_serve", 1'b0, 0, 3, 1'b0);
        frame(0);
        frame(0);
        expect_now("serve_2_ticks", 1'b0, 0, 3, 1'b0);
        frame(0);
        expect_now("serve_to_play", 1'b1, 0, 3, 1'b0);
        step(90);
        start = 1'b0;
        step(3);

        for (int i = 0; i < 5; i++) hit();
        expect_now("score_5", 1'b1, 5, 3, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_now("reset_mid_play", 1'b0, 0, 0, 1'b0);

        push(K_LOAD, "load_after_reset", 1'b0, 0, 3, 1'b0, -1);
        press();
        for (int i = 0; i < 3; i++) frame(0);
        for (int i = 0; i < 300; i++) hit();
        expect_now("score_saturate", 1'b1, 255, 3, 1'b0);

        frame(447);
        expect_now("y447_no_miss", 1'b1, 255, 3, 1'b0);
        frame(448);
        expect_now("miss1_state", 1'b0, 255, 2, 1'b0);
        push(K_LOAD, "miss1_reload", 1'b0, 255, 2, 1'b0, -1);
        step(1);
        for (int i = 0; i < 3; i++) frame(0);
        frame(448);
        expect_now("miss2_state", 1'b0, 255, 1, 1'b0);
        push(K_LOAD, "miss2_reload", 1'b0, 255, 1, 1'b0, -1);
        step(1);
        for (int i = 0; i < 3; i++) frame(0);
        frame(500);
        expect_now("miss3_state", 1'b0, 255, 0, 1'b0);
        expect_now("game_over", 1'b0, 255, 0, 1'b1);
        hit();
        frame(448);
        expect_now("over_holds", 1'b0, 255, 0, 1'b1);

        push(K_LOAD, "restart_load", 1'b0, 0, 3, 1'b0, -1);
        press();
        for (int i = 0; i < 3; i++) frame(0);
        for (int i = 0; i < 7; i++) hit();
        expect_now("score_7", 1'b1, 7, 3, 1'b0);
        frame(448);
        expect_now("miss_to_2", 1'b0, 7, 2, 1'b0);
        push(K_LOAD, "reload_2", 1'b0, 7, 2, 1'b0, -1);
        step(1);
        for (int i = 0; i < 3; i++) frame(0);

        paddle_hit = 1'b1;
        frame(448);
        paddle_hit = 1'b0;
        expect_now("hit_and_miss", 1'b0, 8, 1, 1'b0);
        push(K_LOAD, "hit_miss_reload", 1'b0, 8, 1, 1'b0, -1);
        step(1);
        for (int i = 0; i < 3; i++) frame(0);
        expect_now("replay_after_hm", 1'b1, 8, 1, 1'b0);
        press();
        expect_now("start_in_play", 1'b1, 8, 1, 1'b0);

        step(4);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL leftover_expectations: got %0d pending, want 0", q.size());
        end
        tests++;
        if (load_cnt != exp_loads) begin
            fails++;
            $display("FAIL load_pulse_count: got %0d, want %0d", load_cnt, exp_loads);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
